// File: rtl/tag_packet_parser.sv
// Tag packet consumer: checks framing of the 32-bit tag stream, splits it into a
// frame header and a stream of 4-word target records, and flags malformed packets.
module tag_packet_parser #(
    parameter logic [15:0] MAGIC = 16'h7A67
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tag_tdata,
    input  logic        tag_tvalid,
    input  logic        tag_tlast,
    output logic        tag_tready,
    output logic        hdr_valid,
    output logic [31:0] hdr_timestamp,
    output logic [15:0] hdr_hsize,
    output logic [15:0] hdr_vsize,
    output logic [15:0] hdr_count,
    output logic        tgt_valid,
    input  logic        tgt_ready,
    output logic [31:0] tgt_x,
    output logic [31:0] tgt_y,
    output logic [7:0]  tgt_level,
    output logic [23:0] tgt_size,
    output logic [31:0] tgt_index,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        err_magic,
    output logic        err_length,
    output logic [15:0] err_cnt
);
    typedef enum logic [2:0] {S_HDR, S_TS, S_SIZE, S_T0, S_T1, S_T2, S_T3, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d, rec_cnt_q, rec_cnt_d, err_cnt_q, err_cnt_d;
    logic [31:0] ts_q, ts_d, x_stg_q, x_stg_d, y_stg_q, y_stg_d, ls_stg_q, ls_stg_d;
    logic [15:0] hsize_q, hsize_d, vsize_q, vsize_d;
    logic [31:0] tx_q, tx_d, ty_q, ty_d, tls_q, tls_d, tidx_q, tidx_d;
    logic        tgt_valid_q, tgt_valid_d, hdr_valid_q, hdr_valid_d;
    logic        pkt_done_q, pkt_done_d, pkt_ok_q, pkt_ok_d;
    logic        err_magic_q, err_magic_d, err_length_q, err_length_d;
    logic        acc, framed, last_exp;

    assign tag_tready = !tgt_valid_q || tgt_ready;
    assign acc        = tag_tvalid && tag_tready;

    // Word that must carry tlast: the size word of an empty packet, or the final record's index word.
    assign last_exp = (state_q == S_SIZE && count_q == 16'd0) ||
                      (state_q == S_T3 && (rec_cnt_q + 16'd1) == count_q);
    assign framed   = (state_q inside {S_TS, S_SIZE, S_T0, S_T1, S_T2, S_T3}) ||
                      (state_q == S_HDR && tag_tdata[31:16] == MAGIC);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rec_cnt_d    = rec_cnt_q;
        ts_d         = ts_q;
        hsize_d      = hsize_q;
        vsize_d      = vsize_q;
        x_stg_d      = x_stg_q;
        y_stg_d      = y_stg_q;
        ls_stg_d     = ls_stg_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        tls_d        = tls_q;
        tidx_d       = tidx_q;
        tgt_valid_d  = tgt_valid_q && !tgt_ready;
        hdr_valid_d  = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_ok_d     = 1'b0;
        err_magic_d  = 1'b0;
        err_length_d = 1'b0;
        if (acc) begin
            case (state_q)
                S_HDR: begin
                    if (tag_tdata[31:16] == MAGIC) begin
                        count_d = tag_tdata[15:0];
                        state_d = S_TS;
                    end else begin
                        err_magic_d = 1'b1;
                        pkt_done_d  = tag_tlast;
                        state_d     = tag_tlast ? S_HDR : S_DRAIN;
                    end
                end
                S_TS: begin
                    ts_d    = tag_tdata;
                    state_d = S_SIZE;
                end
                S_SIZE: begin
                    hsize_d     = tag_tdata[15:0];
                    vsize_d     = tag_tdata[31:16];
                    hdr_valid_d = 1'b1;
                    rec_cnt_d   = 16'd0;
                    state_d     = S_T0;
                end
                S_T0: begin x_stg_d  = tag_tdata; state_d = S_T1; end
                S_T1: begin y_stg_d  = tag_tdata; state_d = S_T2; end
                S_T2: begin ls_stg_d = tag_tdata; state_d = S_T3; end
                S_T3: begin
                    tx_d        = x_stg_q;
                    ty_d        = y_stg_q;
                    tls_d       = ls_stg_q;
                    tidx_d      = tag_tdata;
                    tgt_valid_d = 1'b1;
                    rec_cnt_d   = rec_cnt_q + 16'd1;
                    state_d     = S_T0;
                end
                default: begin
                    if (tag_tlast) begin
                        pkt_done_d = 1'b1;
                        state_d    = S_HDR;
                    end
                end
            endcase
            // Framing overrides the normal advance for words inside a recognised packet.
            if (framed) begin
                if (tag_tlast) begin
                    pkt_done_d   = 1'b1;
                    pkt_ok_d     = last_exp;
                    err_length_d = !last_exp;
                    state_d      = S_HDR;
                end else if (last_exp) begin
                    err_length_d = 1'b1;
                    state_d      = S_DRAIN;
                end
            end
        end
        err_cnt_d = err_cnt_q + {15'd0, err_magic_d || err_length_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HDR;
            count_q      <= '0;
            rec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            ts_q         <= '0;
            hsize_q      <= '0;
            vsize_q      <= '0;
            x_stg_q      <= '0;
            y_stg_q      <= '0;
            ls_stg_q     <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            tls_q        <= '0;
            tidx_q       <= '0;
            tgt_valid_q  <= 1'b0;
            hdr_valid_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_ok_q     <= 1'b0;
            err_magic_q  <= 1'b0;
            err_length_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rec_cnt_q    <= rec_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ts_q         <= ts_d;
            hsize_q      <= hsize_d;
            vsize_q      <= vsize_d;
            x_stg_q      <= x_stg_d;
            y_stg_q      <= y_stg_d;
            ls_stg_q     <= ls_stg_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            tls_q        <= tls_d;
            tidx_q       <= tidx_d;
            tgt_valid_q  <= tgt_valid_d;
            hdr_valid_q  <= hdr_valid_d;
            pkt_done_q   <= pkt_done_d;
            pkt_ok_q     <= pkt_ok_d;
            err_magic_q  <= err_magic_d;
            err_length_q <= err_length_d;
        end
    end

    assign hdr_valid     = hdr_valid_q;
    assign hdr_timestamp = ts_q;
    assign hdr_hsize     = hsize_q;
    assign hdr_vsize     = vsize_q;
    assign hdr_count     = count_q;
    assign tgt_valid     = tgt_valid_q;
    assign tgt_x         = tx_q;
    assign tgt_y         = ty_q;
    assign tgt_level     = tls_q[7:0];
    assign tgt_size      = tls_q[31:8];
    assign tgt_index     = tidx_q;
    assign pkt_done      = pkt_done_q;
    assign pkt_ok        = pkt_ok_q;
    assign err_magic     = err_magic_q;
    assign err_length    = err_length_q;
    assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_tag_packet_parser.sv
// Directed bench for tag_packet_parser: header/record/packet/error expectations are
// queued as words are driven and checked as the parser emits them.
module tb_tag_packet_parser;
    localparam logic [15:0] MAGIC = 16'h7A67;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] tag_tdata = '0;
    logic        tag_tvalid = 1'b0, tag_tlast = 1'b0, tag_tready;
    logic        hdr_valid, tgt_valid, tgt_ready = 1'b1;
    logic [31:0] hdr_timestamp, tgt_x, tgt_y, tgt_index;
    logic [15:0] hdr_hsize, hdr_vsize, hdr_count, err_cnt;
    logic [7:0]  tgt_level;
    logic [23:0] tgt_size;
    logic        pkt_done, pkt_ok, err_magic, err_length;

    always #5 clk = ~clk;

    tag_packet_parser dut (
        .clk(clk), .rst(rst),
        .tag_tdata(tag_tdata), .tag_tvalid(tag_tvalid), .tag_tlast(tag_tlast), .tag_tready(tag_tready),
        .hdr_valid(hdr_valid), .hdr_timestamp(hdr_timestamp), .hdr_hsize(hdr_hsize),
        .hdr_vsize(hdr_vsize), .hdr_count(hdr_count),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .tgt_level(tgt_level), .tgt_size(tgt_size), .tgt_index(tgt_index),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_magic(err_magic), .err_length(err_length),
        .err_cnt(err_cnt)
    );

    typedef struct { logic [31:0] x, y; logic [7:0] lvl; logic [23:0] sz; logic [31:0] idx; } rec_t;
    typedef struct { logic [31:0] ts; logic [15:0] hs, vs, cnt; } hdr_t;

    hdr_t     hdr_q[$];
    rec_t     rec_q[$];
    bit       ok_q[$];
    bit [1:0] err_q[$];   // {length, magic}
    int       checks = 0, errors = 0;
    logic [15:0] exp_err_cnt = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    hdr_t eh;
    rec_t er, held;
    bit   held_v = 1'b0, eok;
    bit [1:0] eerr;

    always @(negedge clk) if (!rst) begin
        if (hdr_valid) begin
            if (hdr_q.size() == 0) chk("hdr_unexpected", 1, 0);
            else begin
                eh = hdr_q.pop_front();
                chk("hdr_ts", hdr_timestamp, eh.ts);
                chk("hdr_size", {hdr_vsize, hdr_hsize}, {eh.vs, eh.hs});
                chk("hdr_count", hdr_count, eh.cnt);
            end
        end
        if (tgt_valid && tgt_ready) begin
            if (rec_q.size() == 0) chk("rec_unexpected", 1, 0);
            else begin
                er = rec_q.pop_front();
                chk("rec_xy", {tgt_x, tgt_y}, {er.x, er.y});
                chk("rec_lvl_sz", {tgt_size, tgt_level}, {er.sz, er.lvl});
                chk("rec_index", tgt_index, er.idx);
            end
        end
        if (tgt_valid && !tgt_ready) begin
            chk("tready_stall", tag_tready, 0);
            if (held_v) begin
                chk("stall_xy", {tgt_x, tgt_y}, {held.x, held.y});
                chk("stall_idx", {tgt_index, tgt_size, tgt_level}, {held.idx, held.sz, held.lvl});
            end
            held = '{tgt_x, tgt_y, tgt_level, tgt_size, tgt_index};
            held_v = 1'b1;
        end else held_v = 1'b0;
        if (pkt_done) begin
            if (ok_q.size() == 0) chk("pkt_unexpected", 1, 0);
            else begin eok = ok_q.pop_front(); chk("pkt_ok", pkt_ok, eok); end
        end
        if (err_magic || err_length) begin
            if (err_q.size() == 0) chk("err_unexpected", {err_length, err_magic}, 0);
            else begin eerr = err_q.pop_front(); chk("err_kind", {err_length, err_magic}, eerr); end
        end
    end

    // Holds one word until the parser accepts it; sampled on the falling edge.
    task automatic send(input logic [31:0] d, input bit last);
        bit acc = 1'b0;
        int n = 0;
        tag_tvalid = 1'b1; tag_tdata = d; tag_tlast = last;
        while (!acc && n < 200) begin
            @(negedge clk); acc = tag_tready;
            @(posedge clk); #1; n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        tag_tvalid = 1'b0; tag_tlast = 1'b0;
    endtask

    task automatic mk_rec(output rec_t r);
        r.x = $urandom; r.y = $urandom; r.lvl = 8'($urandom);
        r.sz = 24'($urandom); r.idx = $urandom;
    endtask

    task automatic send_rec(input rec_t r, input int last_at);
        send(r.x, last_at == 0);
        send(r.y, last_at == 1);
        send({r.sz, r.lvl}, last_at == 2);
        send(r.idx, last_at == 3);
    endtask

    task automatic send_hdr(input logic [15:0] cnt, input logic [31:0] ts,
                            input logic [15:0] hs, input logic [15:0] vs, input bit last);
        hdr_q.push_back('{ts, hs, vs, cnt});
        send({MAGIC, cnt}, 1'b0);
        send(ts, 1'b0);
        send({vs, hs}, last);
    endtask

    task automatic good_pkt(input logic [15:0] cnt, input logic [31:0] ts,
                            input logic [15:0] hs, input logic [15:0] vs);
        rec_t r;
        send_hdr(cnt, ts, hs, vs, cnt == 0);
        for (int i = 0; i < int'(cnt); i++) begin
            mk_rec(r);
            rec_q.push_back(r);
            send_rec(r, (i == int'(cnt) - 1) ? 3 : -1);
        end
        ok_q.push_back(1'b1);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        chk("err_cnt", err_cnt, exp_err_cnt);
    endtask

    initial begin
        rec_t r;
        int   n;
        #2;
        chk("rst_outputs", {hdr_valid, tgt_valid, pkt_done, pkt_ok, err_magic, err_length}, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Nominal two-record packet and an empty packet.
        good_pkt(16'd2, 32'h0001_2345, 16'd1920, 16'd1080);
        settle();
        good_pkt(16'd0, 32'hCAFE_0000, 16'd640, 16'd480);
        settle();

        // Bad magic: drained through tlast, then a clean packet.
        err_q.push_back(2'b01); ok_q.push_back(1'b0); exp_err_cnt++;
        send(32'h1234_0001, 1'b0);
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b1);
        settle();
        good_pkt(16'd1, 32'h0000_0042, 16'd320, 16'd240);
        settle();

        // count=3 but tlast on the 6th record word: one record, then early-tlast error.
        send_hdr(16'd3, 32'h0000_0100, 16'd100, 16'd50, 1'b0);
        mk_rec(r); rec_q.push_back(r); send_rec(r, -1);
        err_q.push_back(2'b10); ok_q.push_back(1'b0); exp_err_cnt++;
        mk_rec(r);
        send(r.x, 1'b0);
        send(r.y, 1'b1);
        settle();

        // count=1 with no tlast on the index word: record kept, error, drain.
        send_hdr(16'd1, 32'h0000_0200, 16'd8, 16'd8, 1'b0);
        mk_rec(r); rec_q.push_back(r);
        err_q.push_back(2'b10); exp_err_cnt++;
        send_rec(r, -1);
        ok_q.push_back(1'b0);
        send(32'hDEAD_0001, 1'b0);
        send(32'hDEAD_0002, 1'b1);
        settle();

        // Downstream stall of 10 cycles on the first record of a count=3 packet.
        fork
            good_pkt(16'd3, 32'h0000_0300, 16'd64, 16'd32);
            begin
                n = 0;
                while (!tgt_valid && n < 100) begin @(posedge clk); #1; n++; end
                chk("stall_wait", tgt_valid, 1);
                tgt_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 tgt_ready = 1'b1;
            end
        join
        settle();

        // Reset mid-record of a count=4 packet.
        send_hdr(16'd4, 32'h0000_0400, 16'd16, 16'd16, 1'b0);
        send(32'h0000_1000, 1'b0);
        send(32'h0000_1001, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {hdr_valid, tgt_valid, pkt_done, err_magic, err_length}, 0);
        chk("rst_mid_fields", {hdr_timestamp, tgt_index}, 0);
        chk("rst_mid_err_cnt", err_cnt, 0);
        exp_err_cnt = 16'd0;
        @(posedge clk); #1 rst = 1'b0;
        err_q.push_back(2'b01); ok_q.push_back(1'b0); exp_err_cnt++;
        for (int i = 2; i < 16; i++) send(32'h0000_1000 + 32'(i), i == 15);
        settle();
        good_pkt(16'd2, 32'h0000_0500, 16'd1920, 16'd1080);
        settle();

        chk("hdr_q_empty", hdr_q.size(), 0);
        chk("rec_q_empty", rec_q.size(), 0);
        chk("ok_q_empty", ok_q.size(), 0);
        chk("err_q_empty", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tag_packet_parser.md
# tag_packet_parser

Consumer end of the 32-bit AXI-stream tag packet emitted by the image processor's tag output. Validates the packet, splits it into a per-frame header (timestamp, frame size, target count) and a stream of per-target records, and flags malformed packets. Sits on the control-side PS/PL bridge and on test benches as the checker for the tag path.

## Interface
- MAGIC, 16'h7A67, required value of header word bits [31:16]
- clk  in  1  processing clock; every flop is on its rising edge
- rst  in  1  asynchronous, active-high reset
- tag_tdata  in  32  packet word
- tag_tvalid  in  1  word valid
- tag_tlast  in  1  last word of packet
- tag_tready  out  1  word accepted when tag_tvalid && tag_tready
- hdr_valid  out  1  one-cycle pulse; header fields valid
- hdr_timestamp  out  32  frame timestamp
- hdr_hsize / hdr_vsize  out  16 each  frame size
- hdr_count  out  16  number of target records announced
- tgt_valid  out  1  target record valid; held until tgt_ready
- tgt_ready  in  1  downstream accepts record
- tgt_x / tgt_y  out  32 each  fixed-point centroid, 12.10 in low 22 bits
- tgt_level  out  8  peak level
- tgt_size  out  24  pixel count
- tgt_index  out  32  index word
- pkt_done  out  1  one-cycle pulse on accepted tlast
- pkt_ok  out  1  valid with pkt_done; 1 = well-formed
- err_magic / err_length  out  1 each  one-cycle error pulses
- err_cnt  out  16  malformed packet counter, wraps

## Operation
- Packet format (word order): W0 {MAGIC, count[15:0]}; W1 timestamp; W2 {vsize, hsize}; then count records of 4 words: x, y, {size[23:0], level[7:0]}, index. tlast on the final word only (on W2 when count=0).
- States: HDR, TS, SIZE, T0, T1, T2, T3, DRAIN. Transitions only on accepted words.
- HDR: W0[31:16]==MAGIC -> latch count, go TS; else pulse err_magic, go DRAIN (or, if tlast on that word, stay HDR with pkt_done, pkt_ok=0).
- TS: latch timestamp -> SIZE. SIZE: latch sizes, pulse hdr_valid next cycle; count=0 -> expect tlast, go HDR; else -> T0, clear record counter.
- T0..T2: load x, y, {size,level} into staging regs. T3: load index, transfer staging into output regs, set tgt_valid, increment record counter; counter==count -> expect tlast, go HDR; else T0.
- Length rules: tlast on any word before the expected last word -> err_length, pkt_done with pkt_ok=0, go HDR; expected last word without tlast -> err_length, go DRAIN.
- DRAIN: discard words until accepted tlast, then pkt_done with pkt_ok=0, go HDR. Only one err_* pulse per packet.
- err_cnt increments once per malformed packet, at its first error.
- Records already emitted before an error are not retracted.

## Timing
- tag_tready = !tgt_valid || tgt_ready, in every state (combinational from tgt_ready). Upstream stalls only while an unconsumed record is held.
- hdr_valid, pkt_done, pkt_ok, err_* are registered: asserted the cycle after the causing word is accepted, for exactly one cycle.
- tgt_valid rises the cycle after the T3 word is accepted; drops the cycle after tgt_valid && tgt_ready unless a new T3 word was accepted in the same cycle (back-to-back: stays high, data updates).
- Full throughput: one word per cycle with tgt_ready held high.
- Reset: all outputs 0, state HDR, counters 0. Reset mid-packet discards it; remaining words of that packet hit HDR -> err_magic -> DRAIN.
- Output record fields stable while tgt_valid && !tgt_ready.

## Test plan
- count=2 packet, timestamp 32'h0001_2345, 1920x1080, tgt_ready=1, no gaps -> hdr_valid once with those values and count 2; two tgt_valid pulses with the sent x/y/level/size/index; pkt_done with pkt_ok=1; err_cnt 0.
- count=0 packet, tlast on W2 -> hdr_valid, no tgt_valid, pkt_done with pkt_ok=1.
- W0 = 32'h1234_0001 -> err_magic pulse, rest discarded through tlast, pkt_done with pkt_ok=0, err_cnt 1; following good packet parses normally.
- count=3 but tlast on the 6th record word -> one record emitted, err_length, pkt_done with pkt_ok=0; count=1 without tlast on word 7 -> err_length, drain to tlast.
- tgt_ready held low 10 cycles during count=3 packet -> tag_tready low while record held, record stable, no words lost; all three records delivered in order.
- rst asserted mid-record of a count=4 packet -> outputs 0 immediately; leftover words -> err_magic and drain; next packet correct.
